spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 26 ++
 rtl/spi_slave.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI pin and host-side transmit/receive bundle of the SPI slave.
// The slave modport is the DUT view; the master modport drives it from outside.
interface spi_slave_if #(
  parameter int DATA_W = 16
);
  logic              sck;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport slave (
    input  sck, cs, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output sck, cs, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four modes, variable frame length, oversampled on clk.
// Optional SPI_SLAVE_ABORT_FLAG_EN adds a frame_err pulse output.
module spi_slave #(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width,
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  output logic                         frame_err,
`endif
  spi_slave_if.slave                   bus
);
  localparam int DW = 1 << SPI_MAX_WIDTH_LOG;
  localparam logic [SPI_MAX_WIDTH_LOG-1:0] CNT_ONE = 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                       r_state, w_state_next;
  logic [SYNC_STAGES-1:0]       r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                         r_sck_prev, r_cs_prev;
  logic                         r_cpol, r_cpha;
  logic [SPI_MAX_WIDTH_LOG-1:0] r_bit_cnt;
  logic [DW-2:0]                r_rx_shift;
  logic [DW-1:0]                r_tx_shift, r_shadow, r_rx_data;
  logic                         r_shadow_full, r_rx_valid;

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic w_lead, w_trail, w_sample, w_shift, w_last_bit;
  logic w_start, w_done, w_xfer;
  logic [DW-1:0] w_rx_full, w_rx_mask;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sck_rise = w_sck_s & ~r_sck_prev;
  assign w_sck_fall = ~w_sck_s & r_sck_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs_s & r_cs_prev;
  assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample   = (r_state == ST_ACTIVE) & (r_cpha ? w_trail : w_lead);
  assign w_shift    = (r_state == ST_ACTIVE) & (r_cpha ? w_lead : w_trail);
  assign w_last_bit = (r_bit_cnt == spi_width);
  assign w_start    = (r_state == ST_IDLE) & w_cs_fall;
  assign w_done     = w_sample & w_last_bit;
  assign w_xfer     = w_start | w_done;
  assign w_rx_full  = {r_rx_shift, w_mosi_s};

  always_comb begin
    w_rx_mask = '0;
    for (int i = 0; i < DW; i++) w_rx_mask[i] = (i <= int'(spi_width));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first, so no path leaves w_state_next unassigned and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
    end else begin
      r_rx_valid <= w_done;
      if (w_start) begin
        r_cpol     <= cpol;
        r_cpha     <= cpha;
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end
      if (w_sample) begin
        r_rx_shift <= w_rx_full[DW-2:0];
        r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + CNT_ONE;
        if (w_last_bit) r_rx_data <= w_rx_full & w_rx_mask;
      end
      // A shift edge at count 0 comes before any sample of the current frame
      // (cpha=1 first edge, or the edge right after a back-to-back reload).
      if (w_xfer)
        r_tx_shift <= r_shadow_full ? r_shadow : '0;
      else if (w_shift && (r_bit_cnt != '0))
        r_tx_shift <= {r_tx_shift[DW-2:0], 1'b0};
      if (w_xfer) r_shadow_full <= 1'b0;
      // Load uses the pre-edge full flag, so a coincident transfer takes the old content.
      if (bus.tx_load && !r_shadow_full) begin
        r_shadow      <= bus.tx_data;
        r_shadow_full <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic w_abort, r_frame_err;
  assign w_abort = (r_state == ST_ACTIVE) & w_cs_rise & ~w_done & (r_bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_abort | (w_start & ~r_shadow_full);
  end
  assign frame_err = r_frame_err;
`endif

  assign bus.miso     = (r_state == ST_ACTIVE) & r_tx_shift[spi_width];
  assign bus.busy     = (r_state == ST_ACTIVE);
  assign bus.tx_ready = ~r_shadow_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
endmodule
